// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that drains a FIFO: pops a byte whenever the FIFO is
// non-empty and the line is idle, then shifts it out LSB-first.
module fifo_uart_tx #(
    parameter int ClkFreq    = 27_000_000,
    parameter int BaudRate   = 115200,
    parameter int Width      = 8,
    parameter int ClksPerBit = ClkFreq / BaudRate
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_empty,
    input  logic [Width-1:0] i_data,
    output logic             o_rd,
    output logic             o_tx,
    output logic             o_busy
);

    localparam int CntW = $clog2(ClksPerBit);
    localparam int IdxW = $clog2(Width + 1);

    if (ClksPerBit < 2) begin : g_bad_cfg
        $error("fifo_uart_tx: ClksPerBit must be at least 2");
    end

    typedef enum logic [2:0] {
        IDLE,
        POP,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [CntW-1:0]   r_clk_cnt;
    logic [IdxW-1:0]   r_bit_idx;
    logic [Width-1:0]  r_shift;
    logic              w_bit_end;

    assign w_bit_end = (r_clk_cnt == CntW'(ClksPerBit - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    // FIFO read data is valid here, one cycle after the POP strobe.
                    r_shift   <= i_data;
                    r_clk_cnt <= '0;
                end
                START, DATA, STOP: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        if (r_state == START) begin
                            r_bit_idx <= '0;
                        end else if (r_state == DATA) begin
                            r_shift   <= {1'b0, r_shift[Width-1:1]};
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        o_rd         = 1'b0;
        o_tx         = 1'b1;
        o_busy       = (r_state != IDLE);

        case (r_state)
            IDLE: begin
                if (!i_empty) begin
                    w_state_next = POP;
                end
            end
            POP: begin
                o_rd         = 1'b1;
                w_state_next = LOAD;
            end
            LOAD: begin
                w_state_next = START;
            end
            START: begin
                o_tx = 1'b0;
                if (w_bit_end) begin
                    w_state_next = DATA;
                end
            end
            DATA: begin
                o_tx = r_shift[0];
                if (w_bit_end && (r_bit_idx == IdxW'(Width - 1))) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_bit_end) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Reader-side consumer for the team's `fifo` block; drains bytes from the FIFO and serialises them onto a UART TX line.
- Format is 8N1: one start bit, 8 data bits LSB-first, one stop bit, no parity.
- Connects directly to the FIFO `o_empty`/`i_rd`/`o_data` pins and drives the board TX pin.
- Runs continuously: transmits back-to-back while the FIFO is non-empty.

Parameters:
- ClkFreq, 27_000_000, input clock frequency in Hz.
- BaudRate, 115200, line rate in bit/s.
- Width, 8, data bits per frame; must match the FIFO Width.
- ClksPerBit, ClkFreq/BaudRate (integer truncation; 234 at defaults), clocks per bit period.
  - Elaboration error if ClksPerBit < 2.

Ports:
- i_clk  input  1  system clock.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_empty  input  1  FIFO empty flag (FIFO `o_empty`).
- i_data  input  Width  FIFO read data (FIFO `o_data`); valid on the cycle after a read strobe.
- o_rd  output  1  FIFO read strobe (FIFO `i_rd`); single-cycle pulse.
- o_tx  output  1  UART serial line; idle high.
- o_busy  output  1  high whenever a frame is in progress (state != IDLE).

Behaviour:
- Reset (async, i_rst_n=0): state IDLE, o_tx=1, o_rd=0, o_busy=0, bit/clock counters and shift register cleared.
  - Takes effect immediately, including mid-frame.
  - A byte already popped but not fully sent is lost.
- Registered FSM states: IDLE, POP, LOAD, START, DATA, STOP. All outputs are Moore, derived from the state/registers.
- IDLE: o_tx=1. If i_empty=0 at a rising edge, go to POP; otherwise stay.
- POP: o_rd=1 for exactly this one cycle; next state LOAD. The FIFO pops on the edge leaving POP.
- LOAD: at the edge leaving LOAD, capture i_data into the shift register and clear the clock counter; next state START.
  - o_rd=0 in LOAD.
- START: o_tx=0 for ClksPerBit cycles, then DATA with bit index 0.
- DATA: o_tx = shift[0] for ClksPerBit cycles per bit.
  - After each bit: shift right, increment index.
  - After bit Width-1, go to STOP.
- STOP: o_tx=1 for ClksPerBit cycles, then IDLE.
- Latency: empty deasserted at edge N gives o_rd=1 during cycle N..N+1; o_tx falls after edge N+2.
- Frame length is exactly (Width+2)*ClksPerBit cycles from o_tx fall to STOP exit.
- Back-to-back: the IDLE→POP→LOAD path inserts exactly 3 extra high cycles after the stop bit, so the line is high for ClksPerBit+3 cycles between frames.
- o_rd rules:
  - Never asserted while i_empty=1, because the empty check is made in IDLE only.
  - Never asserted more than once per frame.
  - Never asserted in consecutive cycles.
- i_empty changes during a frame are ignored; the next byte is fetched only after return to IDLE.
- i_data is sampled only in LOAD; changes at any other time have no effect on the frame in flight.
- Clock counter width is clog2(ClksPerBit); bit index width is clog2(Width+1). Counters wrap to 0 at each bit boundary.
- Simultaneous FIFO write and our read on the same edge is the FIFO's concern; this block only guarantees o_rd qualification as above.

Test Plan:
- Bench configuration for all scenarios: ClkFreq=1_000_000, BaudRate=250_000 (ClksPerBit=4), Width=8, driving the real `fifo` with Depth=2.
- Reset idle: hold i_rst_n=0 10 cycles then release with FIFO empty → o_tx=1, o_rd=0, o_busy=0 for 50 cycles.
- Single byte: write 0xA5 → exactly one o_rd pulse; o_tx falls 2 cycles later.
  - Line reads 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; total low-to-stop-end 40 cycles.
  - o_busy falls, FIFO empty.
- Burst: write 0xAA,0xBB,0xCC,0xDD,0xEE,0xFF as fast as the FIFO accepts, writing only when not full.
  - Receiver model decodes the same 6 bytes in order.
  - Inter-frame high time = 7 cycles.
  - Exactly 6 o_rd pulses, none while empty.
- Empty mid-frame: write one byte, then write 0x3C during its DATA phase → second frame starts 3 cycles after the first stop bit ends and decodes 0x3C.
- Reset mid-frame: assert i_rst_n=0 during bit 3 of 0x55 → o_tx=1 and o_busy=0 immediately (asynchronously).
  - After release, no partial frame completes.
  - Any remaining FIFO bytes transmit normally.
- Assertion checker: o_rd && i_empty never true; o_rd never high on two consecutive cycles; o_tx=1 whenever o_busy=0.
